// File: rtl/exe_muldiv_unit.sv
// Multi-cycle multiply/divide unit for the EXE stage: HI/LO results for MULT(U)/DIV(U),
// with the MADD/MSUB accumulate family built only when MDU_ACCUMULATE_EN is defined.
module exe_muldiv_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int MUL_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  MDU_Valid,
  output logic                  MDU_Ready,
  input  logic [2:0]            MDU_Op,
  input  logic [DATA_WIDTH-1:0] MDU_SrcA,
  input  logic [DATA_WIDTH-1:0] MDU_SrcB,
  input  logic [DATA_WIDTH-1:0] MDU_Hi_In,
  input  logic [DATA_WIDTH-1:0] MDU_Lo_In,
  input  logic                  MDU_Flush,
  output logic                  MDU_Busy,
  output logic                  MDU_Done,
  output logic [DATA_WIDTH-1:0] MDU_Hi,
  output logic [DATA_WIDTH-1:0] MDU_Lo
);

  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  // r_a: multiplicand, or dividend magnitude shifting out while quotient bits shift in
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic [W-1:0]     r_rem;
  logic             r_uns;
  logic             r_nop;
  logic             r_q_neg;
  logic             r_r_neg;
  logic             r_done;
  logic [W-1:0]     r_hi;
  logic [W-1:0]     r_lo;

  logic [2*W-1:0]   w_a_ext;
  logic [2*W-1:0]   w_b_ext;
  logic [2*W-1:0]   w_prod;
  logic [2*W-1:0]   w_mul_res;
  logic [W-1:0]     w_a_mag;
  logic [W-1:0]     w_b_mag;
  logic [W:0]       w_shift;
  logic [W:0]       w_diff;
  logic             w_is_div;

`ifdef MDU_ACCUMULATE_EN
  logic             r_acc;
  logic             r_sub;
  logic [2*W-1:0]   r_acc_in;
  logic [2*W-1:0]   r_prod;
  logic [2*W-1:0]   w_acc_res;
`else
  logic             w_unused_acc;
`endif

  assign MDU_Ready = (r_state == S_IDLE);
  assign MDU_Busy  = (r_state != S_IDLE);
  assign MDU_Done  = r_done;
  assign MDU_Hi    = r_hi;
  assign MDU_Lo    = r_lo;

  assign w_is_div = (MDU_Op[2:1] == 2'b01);
  assign w_a_ext  = {{W{~r_uns & r_a[W-1]}}, r_a};
  assign w_b_ext  = {{W{~r_uns & r_b[W-1]}}, r_b};
  assign w_prod   = w_a_ext * w_b_ext;
  assign w_a_mag  = (~MDU_Op[0] & MDU_SrcA[W-1]) ? ({W{1'b0}} - MDU_SrcA) : MDU_SrcA;
  assign w_b_mag  = (~MDU_Op[0] & MDU_SrcB[W-1]) ? ({W{1'b0}} - MDU_SrcB) : MDU_SrcB;
  // Partial remainder never exceeds the divisor, so the top bit of w_diff is a clean borrow
  assign w_shift  = {r_rem, r_a[W-1]};
  assign w_diff   = w_shift - {1'b0, r_b};

`ifdef MDU_ACCUMULATE_EN
  assign w_acc_res = r_sub ? (r_acc_in - r_prod) : (r_acc_in + r_prod);
  assign w_mul_res = r_acc ? w_acc_res : w_prod;
`else
  assign w_mul_res    = w_prod;
  assign w_unused_acc = ^{MDU_Hi_In, MDU_Lo_In};
`endif

  // Control FSM, operand capture, divider datapath and registered result outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_cnt   <= {CNT_W{1'b0}};
      r_a     <= {W{1'b0}};
      r_b     <= {W{1'b0}};
      r_rem   <= {W{1'b0}};
      r_uns   <= 1'b0;
      r_nop   <= 1'b0;
      r_q_neg <= 1'b0;
      r_r_neg <= 1'b0;
      r_done  <= 1'b0;
      r_hi    <= {W{1'b0}};
      r_lo    <= {W{1'b0}};
`ifdef MDU_ACCUMULATE_EN
      r_acc    <= 1'b0;
      r_sub    <= 1'b0;
      r_acc_in <= {(2*W){1'b0}};
      r_prod   <= {(2*W){1'b0}};
`endif
    end else begin
      r_done <= 1'b0;
      if (MDU_Flush) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (MDU_Valid) begin
              r_uns <= MDU_Op[0];
              r_nop <= 1'b0;
              if (w_is_div) begin
                if (MDU_SrcB == {W{1'b0}}) begin
                  r_a     <= {W{1'b1}};
                  r_rem   <= MDU_SrcA;
                  r_q_neg <= 1'b0;
                  r_r_neg <= 1'b0;
                  r_state <= S_FIX;
                end else begin
                  r_a     <= w_a_mag;
                  r_b     <= w_b_mag;
                  r_rem   <= {W{1'b0}};
                  r_q_neg <= ~MDU_Op[0] & (MDU_SrcA[W-1] ^ MDU_SrcB[W-1]);
                  r_r_neg <= ~MDU_Op[0] & MDU_SrcA[W-1];
                  r_cnt   <= CNT_W'(W - 1);
                  r_state <= S_DIV;
                end
              end else begin
                r_a     <= MDU_SrcA;
                r_b     <= MDU_SrcB;
                r_state <= S_MUL;
`ifdef MDU_ACCUMULATE_EN
                r_acc    <= MDU_Op[2];
                r_sub    <= MDU_Op[1];
                r_acc_in <= {MDU_Hi_In, MDU_Lo_In};
                r_cnt    <= MDU_Op[2] ? CNT_W'(MUL_STAGES) : CNT_W'(MUL_STAGES - 1);
`else
                // Accumulate ops are not built: retire after one edge without touching HI/LO
                r_nop    <= MDU_Op[2];
                r_cnt    <= MDU_Op[2] ? {CNT_W{1'b0}} : CNT_W'(MUL_STAGES - 1);
`endif
              end
            end
          end
          S_MUL: begin
`ifdef MDU_ACCUMULATE_EN
            r_prod <= w_prod;
`endif
            if (r_cnt == {CNT_W{1'b0}}) begin
              r_state <= S_IDLE;
              r_done  <= 1'b1;
              if (!r_nop) begin
                r_hi <= w_mul_res[2*W-1:W];
                r_lo <= w_mul_res[W-1:0];
              end
            end else begin
              r_cnt <= r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
            end
          end
          S_DIV: begin
            if (!w_diff[W]) begin
              r_rem <= w_diff[W-1:0];
              r_a   <= {r_a[W-2:0], 1'b1};
            end else begin
              r_rem <= w_shift[W-1:0];
              r_a   <= {r_a[W-2:0], 1'b0};
            end
            if (r_cnt == {CNT_W{1'b0}}) begin
              r_state <= S_FIX;
            end else begin
              r_cnt <= r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
            end
          end
          S_FIX: begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
            r_lo    <= r_q_neg ? ({W{1'b0}} - r_a) : r_a;
            r_hi    <= r_r_neg ? ({W{1'b0}} - r_rem) : r_rem;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_exe_muldiv_unit.sv
// Randomized self-checking bench for exe_muldiv_unit against a 64-bit arithmetic reference model.
module tb_exe_muldiv_unit;

  localparam int W  = 32;
  localparam int MS = 2;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          MDU_Valid = 1'b0;
  logic          MDU_Ready;
  logic [2:0]    MDU_Op = 3'd0;
  logic [W-1:0]  MDU_SrcA = 32'd0;
  logic [W-1:0]  MDU_SrcB = 32'd0;
  logic [W-1:0]  MDU_Hi_In = 32'd0;
  logic [W-1:0]  MDU_Lo_In = 32'd0;
  logic          MDU_Flush = 1'b0;
  logic          MDU_Busy;
  logic          MDU_Done;
  logic [W-1:0]  MDU_Hi;
  logic [W-1:0]  MDU_Lo;

  int            n_cmp = 0;
  int            n_mis = 0;
  logic [31:0]   m_hi = 32'd0;
  logic [31:0]   m_lo = 32'd0;

  exe_muldiv_unit #(.DATA_WIDTH(W), .MUL_STAGES(MS)) dut (
    .clk(clk), .resetn(resetn), .MDU_Valid(MDU_Valid), .MDU_Ready(MDU_Ready),
    .MDU_Op(MDU_Op), .MDU_SrcA(MDU_SrcA), .MDU_SrcB(MDU_SrcB),
    .MDU_Hi_In(MDU_Hi_In), .MDU_Lo_In(MDU_Lo_In), .MDU_Flush(MDU_Flush),
    .MDU_Busy(MDU_Busy), .MDU_Done(MDU_Done), .MDU_Hi(MDU_Hi), .MDU_Lo(MDU_Lo)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain signed/unsigned 64-bit arithmetic on the architectural operands
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] hin, input logic [31:0] lin,
                       output logic [31:0] eh, output logic [31:0] el, output int lat);
    longint      sa, sb, sq, sr;
    logic [63:0] p, acc, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op[0]) p = {32'd0, a} * {32'd0, b};
    else       p = sa * sb;
    eh  = p[63:32];
    el  = p[31:0];
    lat = MS;
    case (op)
      3'd2, 3'd3: begin
        if (b == 32'd0) begin
          eh = a; el = 32'hFFFF_FFFF; lat = 1;
        end else begin
          lat = W + 1;
          if (op[0]) begin
            uq = {32'd0, a} / {32'd0, b};
            ur = {32'd0, a} % {32'd0, b};
          end else begin
            sq = sa / sb;
            sr = sa % sb;
            uq = sq;
            ur = sr;
          end
          el = uq[31:0];
          eh = ur[31:0];
        end
      end
      3'd4, 3'd5, 3'd6, 3'd7: begin
`ifdef MDU_ACCUMULATE_EN
        acc = op[1] ? ({hin, lin} - p) : ({hin, lin} + p);
        eh  = acc[63:32];
        el  = acc[31:0];
        lat = MS + 1;
`else
        acc = {hin, lin};
        eh  = m_hi;
        el  = m_lo;
        lat = 1;
`endif
      end
      default: begin
        lat = MS;
      end
    endcase
  endtask

  task automatic wait_done(input int max, output int n, output bit seen);
    n = 0;
    seen = 1'b0;
    while (!seen && n < max) begin
      @(posedge clk);
      n++;
      #1;
      if (MDU_Done === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic scramble();
    MDU_Op    = 3'($urandom_range(0, 7));
    MDU_SrcA  = $urandom;
    MDU_SrcB  = $urandom;
    MDU_Hi_In = $urandom;
    MDU_Lo_In = $urandom;
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] hin, input logic [31:0] lin, input string tag);
    logic [31:0] eh, el;
    int          lat, n;
    bit          seen;
    model(op, a, b, hin, lin, eh, el, lat);
    @(negedge clk);
    MDU_Op = op; MDU_SrcA = a; MDU_SrcB = b; MDU_Hi_In = hin; MDU_Lo_In = lin;
    MDU_Valid = 1'b1;
    @(posedge clk);
    #1;
    MDU_Valid = 1'b0;
    scramble();
    check_eq({tag, "_busy"}, {63'd0, MDU_Busy}, 64'd1);
    wait_done(100, n, seen);
    check_eq({tag, "_done"}, {63'd0, seen}, 64'd1);
    check_eq({tag, "_lat"}, 64'(n), 64'(lat));
    check_eq({tag, "_hi"}, {32'd0, MDU_Hi}, {32'd0, eh});
    check_eq({tag, "_lo"}, {32'd0, MDU_Lo}, {32'd0, el});
    m_hi = eh;
    m_lo = el;
    @(posedge clk);
    #1;
    check_eq({tag, "_pulse"}, {63'd0, MDU_Done}, 64'd0);
    check_eq({tag, "_hold"}, {MDU_Hi, MDU_Lo}, {m_hi, m_lo});
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 9))
      0: v = 32'd0;
      1: v = 32'd1;
      2: v = 32'hFFFF_FFFF;
      3: v = 32'h8000_0000;
      4: v = 32'h7FFF_FFFF;
      5: v = 32'($urandom_range(0, 15));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    int          n, dn;
    bit          seen;

    // Reset state
    #12;
    check_eq("rst_ready", {63'd0, MDU_Ready}, 64'd1);
    check_eq("rst_busy", {63'd0, MDU_Busy}, 64'd0);
    check_eq("rst_done", {63'd0, MDU_Done}, 64'd0);
    check_eq("rst_hilo", {MDU_Hi, MDU_Lo}, 64'd0);
    @(negedge clk);
    resetn = 1'b1;

    // Directed cases
    run_op(3'd0, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0, "mult");
    check_eq("mult_k", {MDU_Hi, MDU_Lo}, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op(3'd1, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0, "multu");
    check_eq("multu_k", {MDU_Hi, MDU_Lo}, 64'h0000_0001_FFFF_FFFE);
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0, "div");
    check_eq("div_k", {MDU_Hi, MDU_Lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(3'd3, 32'd7, 32'd2, 32'd0, 32'd0, "divu");
    check_eq("divu_k", {MDU_Hi, MDU_Lo}, 64'h0000_0001_0000_0003);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, "divovf");
    check_eq("divovf_k", {MDU_Hi, MDU_Lo}, 64'h0000_0000_8000_0000);
    run_op(3'd3, 32'd5, 32'd0, 32'd0, 32'd0, "divz");
    check_eq("divz_k", {MDU_Hi, MDU_Lo}, 64'h0000_0005_FFFF_FFFF);
    run_op(3'd4, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF, "madd");
    run_op(3'd6, 32'd3, 32'd5, 32'd0, 32'd2, "msub");

    // Flush during divide iterations: no Done, HI/LO hold
    @(negedge clk);
    MDU_Op = 3'd2; MDU_SrcA = 32'h1234_5678; MDU_SrcB = 32'd7; MDU_Valid = 1'b1;
    @(posedge clk);
    #1;
    MDU_Valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    MDU_Flush = 1'b1;
    @(posedge clk);
    #1;
    MDU_Flush = 1'b0;
    check_eq("flush_ready", {63'd0, MDU_Ready}, 64'd1);
    check_eq("flush_done", {63'd0, MDU_Done}, 64'd0);
    check_eq("flush_hold", {MDU_Hi, MDU_Lo}, {m_hi, m_lo});
    dn = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (MDU_Done === 1'b1) dn++;
    end
    check_eq("flush_nodone", 64'(dn), 64'd0);
    run_op(3'd1, 32'd3, 32'd4, 32'd0, 32'd0, "postflush");
    check_eq("postflush_k", {MDU_Hi, MDU_Lo}, 64'h0000_0000_0000_000C);

    // Flush together with Valid drops the request
    @(negedge clk);
    MDU_Op = 3'd0; MDU_SrcA = 32'd9; MDU_SrcB = 32'd9; MDU_Valid = 1'b1; MDU_Flush = 1'b1;
    @(posedge clk);
    #1;
    MDU_Valid = 1'b0;
    MDU_Flush = 1'b0;
    check_eq("flushv_busy", {63'd0, MDU_Busy}, 64'd0);

    // Held Valid is ignored while busy and taken in the Done cycle
    @(negedge clk);
    MDU_Op = 3'd3; MDU_SrcA = 32'd9; MDU_SrcB = 32'd3; MDU_Valid = 1'b1;
    @(posedge clk);
    #1;
    MDU_Op = 3'd1; MDU_SrcA = 32'd2; MDU_SrcB = 32'd5;
    check_eq("b2b_ready0", {63'd0, MDU_Ready}, 64'd0);
    wait_done(100, n, seen);
    check_eq("b2b_lat1", 64'(n), 64'(W + 1));
    check_eq("b2b_res1", {MDU_Hi, MDU_Lo}, 64'h0000_0000_0000_0003);
    check_eq("b2b_ready1", {63'd0, MDU_Ready}, 64'd1);
    @(posedge clk);
    #1;
    MDU_Valid = 1'b0;
    check_eq("b2b_busy2", {63'd0, MDU_Busy}, 64'd1);
    wait_done(100, n, seen);
    check_eq("b2b_lat2", 64'(n), 64'(MS));
    check_eq("b2b_res2", {MDU_Hi, MDU_Lo}, 64'h0000_0000_0000_000A);
    m_hi = 32'd0;
    m_lo = 32'd10;
    @(posedge clk);
    #1;

    // Randomized operations
    for (int i = 0; i < 150; i++) begin
      run_op(3'($urandom_range(0, 7)), pick(), pick(), $urandom, $urandom, "rnd");
    end

    // Reset mid-operation
    @(negedge clk);
    MDU_Op = 3'd2; MDU_SrcA = 32'hDEAD_BEEF; MDU_SrcB = 32'd3; MDU_Valid = 1'b1;
    @(posedge clk);
    #1;
    MDU_Valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check_eq("mrst_busy", {63'd0, MDU_Busy}, 64'd0);
    check_eq("mrst_hilo", {MDU_Hi, MDU_Lo}, 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    dn = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (MDU_Done === 1'b1) dn++;
    end
    check_eq("mrst_nodone", 64'(dn), 64'd0);
    m_hi = 32'd0;
    m_lo = 32'd0;
    run_op(3'd0, 32'hFFFF_FFFD, 32'd7, 32'd0, 32'd0, "postrst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
